// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock-divider sequencer: FSM state encodings and reset divide value.
package clkdiv_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  // 16 kHz divided output from a 100 MHz clock
  localparam int unsigned DIV_INIT_DEFAULT = 3124;

  localparam int unsigned TICK_CNT_W = 32;

endpackage

// File: rtl/clkdiv_if.sv
// Divide-value configuration handshake (valid/ready) between a config master and the sequencer.
interface clkdiv_if #(
  parameter int unsigned WIDTH = 16
);

  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);

endinterface

// File: rtl/clkdiv_core.sv
// Half-period counter, compare and output toggle. wrap is combinational so the
// sequencer can act on the same edge that the counter rolls over.
module clkdiv_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             wrap,
  output logic             divided_clk
);

  logic [WIDTH-1:0] count;

  assign wrap = en && (count == div);

  // Count up to div, then restart and toggle the output
  always_ff @(posedge clk) begin
    if (clr) begin
      count       <= '0;
      divided_clk <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        count       <= '0;
        divided_clk <= ~divided_clk;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/clkdiv_sequencer.sv
// Clock-divider sequencer: IDLE/RUN/DRAIN control, divide-value handshake with
// a one-deep pending slot applied on wrap boundaries.
// Optional feature: define CLKDIV_TICKCNT_EN to add the 32-bit tick_count output.
module clkdiv_sequencer
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  clkdiv_if.slave       cfg,
  output logic          divided_clk,
  output logic          tick,
  output logic          busy
`ifdef CLKDIV_TICKCNT_EN
  ,
  output logic [TICK_CNT_W-1:0] tick_count
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] pend_reg;
  logic             pend_valid;
  logic             wrap;
  logic             core_en;
  logic             core_clr;
  logic             xfer;

  assign core_en       = (state != IDLE);
  assign core_clr      = rst || (state == IDLE);
  assign xfer          = cfg.cfg_valid && !pend_valid;
  assign cfg.cfg_ready = ~pend_valid;

  clkdiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .en          (core_en),
    .clr         (core_clr),
    .div         (div_reg),
    .wrap        (wrap),
    .divided_clk (divided_clk)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: DRAIN finishes only on the wrap that drives the output low
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)                      state_nxt = RUN;
        else if (wrap && divided_clk) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Divide value: direct load when idle, otherwise staged and applied at the next wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg    <= WIDTH'(DIV_INIT);
      pend_reg   <= '0;
      pend_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (pend_valid) begin
        div_reg    <= pend_reg;
        pend_valid <= 1'b0;
      end else if (xfer) begin
        div_reg <= cfg.cfg_div;
      end
    end else begin
      if (wrap && pend_valid) begin
        div_reg    <= pend_reg;
        pend_valid <= 1'b0;
      end
      if (xfer) begin
        pend_reg   <= cfg.cfg_div;
        pend_valid <= 1'b1;
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
      busy <= 1'b0;
    end else begin
      tick <= wrap;
      busy <= (state_nxt != IDLE);
    end
  end

`ifdef CLKDIV_TICKCNT_EN
  // Toggle counter, cleared when the sequencer returns to IDLE
  always_ff @(posedge clk) begin
    if (rst)                                    tick_count <= '0;
    else if (state != IDLE && state_nxt == IDLE) tick_count <= '0;
    else if (wrap)                              tick_count <= tick_count + TICK_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// Directed bench for clkdiv_sequencer: hand-computed half-period lengths and handshake states.
module tb_clkdiv_sequencer;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic rst;
  logic run;
  logic divided_clk;
  logic tick;
  logic busy;
`ifdef CLKDIV_TICKCNT_EN
  logic [31:0] tick_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int t_a;
  int t_b;

  clkdiv_if #(.WIDTH(WIDTH)) cfg_bus ();

  clkdiv_sequencer #(.WIDTH(WIDTH), .DIV_INIT(3124)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .cfg         (cfg_bus),
    .divided_clk (divided_clk),
    .tick        (tick),
    .busy        (busy)
`ifdef CLKDIV_TICKCNT_EN
    ,
    .tick_count  (tick_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until tick is seen; returns -1 if the budget runs out
  task automatic wait_tick(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (tick !== 1'b1 && cycles < budget);
    if (tick !== 1'b1) cycles = -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_div   = '0;

    // Reset values
    step();
    chk("rst_dclk",  32'(divided_clk), 32'd0);
    chk("rst_tick",  32'(tick), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    rst = 1'b0;
    step();

    // Default divide 3124: half-period 3125, period 6250, then drain
    run = 1'b1;
    step();
    chk("run_busy", 32'(busy), 32'd1);
    wait_tick(4000, t_a);
    chk("init_first_tick", 32'(t_a), 32'd3125);
    chk("init_dclk_hi", 32'(divided_clk), 32'd1);
    wait_tick(4000, t_a);
    chk("init_dclk_lo", 32'(divided_clk), 32'd0);
    wait_tick(4000, t_b);
    chk("init_period", 32'(t_a + t_b), 32'd6250);
    chk("init_dclk_hi2", 32'(divided_clk), 32'd1);
    run = 1'b0;
    wait_tick(4000, t_a);
    chk("init_drain_len", 32'(t_a), 32'd3125);
    chk("init_drain_dclk", 32'(divided_clk), 32'd0);
    chk("init_drain_busy", 32'(busy), 32'd0);
    step();
    chk("idle_tick", 32'(tick), 32'd0);

    // Idle load of div=4, then run
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 16'd4;
    chk("idle_ready_pre", 32'(cfg_bus.cfg_ready), 32'd1);
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("idle_ready_post", 32'(cfg_bus.cfg_ready), 32'd1);
    run = 1'b1;
    step();
    wait_tick(20, t_a);
    chk("div4_first", 32'(t_a), 32'd5);
    chk("div4_dclk_hi", 32'(divided_clk), 32'd1);
`ifdef CLKDIV_TICKCNT_EN
    chk("tick_count_1", tick_count, 32'd1);
`endif
    wait_tick(20, t_a);
    chk("div4_second", 32'(t_a), 32'd5);
    chk("div4_dclk_lo", 32'(divided_clk), 32'd0);
    chk("div4_ready", 32'(cfg_bus.cfg_ready), 32'd1);

    // Pending load of div=9 while running (counter 0 at offer)
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 16'd9;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("pend9_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    wait_tick(20, t_a);
    chk("pend9_rest_old", 32'(t_a), 32'd4);
    chk("pend9_ready_back", 32'(cfg_bus.cfg_ready), 32'd1);

    // div=9: offer cfg_div=2 at counter=4
    repeat (4) step();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 16'd2;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("div9_ready_lo", 32'(cfg_bus.cfg_ready), 32'd0);
    wait_tick(20, t_a);
    chk("div9_rest", 32'(t_a), 32'd5);
    chk("div9_ready_hi", 32'(cfg_bus.cfg_ready), 32'd1);
    chk("div9_dclk_lo", 32'(divided_clk), 32'd0);
    wait_tick(20, t_a);
    chk("div2_half", 32'(t_a), 32'd3);
    chk("div2_dclk_hi", 32'(divided_clk), 32'd1);

    // Offer div=4 exactly on a wrap cycle of div=2
    step();
    step();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 16'd4;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("wrapx_tick", 32'(tick), 32'd1);
    chk("wrapx_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    wait_tick(20, t_a);
    chk("wrapx_old_half", 32'(t_a), 32'd3);
    chk("wrapx_ready_back", 32'(cfg_bus.cfg_ready), 32'd1);
    wait_tick(20, t_a);
    chk("wrapx_new_half", 32'(t_a), 32'd5);
    chk("wrapx_dclk_lo", 32'(divided_clk), 32'd0);

    // Drop run while divided_clk is high, div=4
    wait_tick(20, t_a);
    chk("drain_pre_half", 32'(t_a), 32'd5);
    chk("drain_pre_dclk", 32'(divided_clk), 32'd1);
    run = 1'b0;
    step();
    chk("drain_busy", 32'(busy), 32'd1);
    wait_tick(20, t_a);
    chk("drain_rest", 32'(t_a), 32'd4);
    chk("drain_dclk", 32'(divided_clk), 32'd0);
    chk("drain_idle_busy", 32'(busy), 32'd0);
    repeat (12) step();
    chk("idle_hold_dclk", 32'(divided_clk), 32'd0);
    chk("idle_hold_busy", 32'(busy), 32'd0);

    // Reset mid-period with a pending value
    run = 1'b1;
    step();
    wait_tick(20, t_a);
    chk("pre_rst_half", 32'(t_a), 32'd5);
    step();
    step();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 16'd7;
    step();
    cfg_bus.cfg_valid = 1'b0;
    chk("pre_rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("pre_rst_dclk", 32'(divided_clk), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_rst_dclk",  32'(divided_clk), 32'd0);
    chk("mid_rst_tick",  32'(tick), 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
`ifdef CLKDIV_TICKCNT_EN
    chk("mid_rst_tick_count", tick_count, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(busy), 32'd1);
    wait_tick(4000, t_a);
    chk("post_rst_first", 32'(t_a), 32'd3125);
    wait_tick(4000, t_a);
    chk("post_rst_second", 32'(t_a), 32'd3125);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_sequencer.md
CLKDIV_SEQUENCER -- requirements
Module: clkdiv_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the divide-value width.
REQ-002 The block SHALL have parameter DIV_INIT, default 3124, the divide value loaded at reset (16 kHz output from 100 MHz).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: level request to generate output.
REQ-006 The block SHALL have port cfg_valid, input, 1 bit: a new divide value is offered.
REQ-007 The block SHALL have port cfg_div, input, WIDTH bits: the offered divide value (half-period minus 1).
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a divide value.
REQ-009 The block SHALL have port divided_clk, output, 1 bit: the square-wave output.
REQ-010 The block SHALL have port tick, output, 1 bit: one-cycle pulse on every divided_clk toggle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN or DRAIN.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DRAIN, and an internal pend_valid flag with a pend_reg register.
REQ-013 A config transfer SHALL occur on any cycle with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL equal ~pend_valid.
REQ-014 In IDLE, an accepted cfg_div SHALL load div_reg directly on that edge; pend_valid SHALL stay 0.
REQ-015 In IDLE, counter=0, divided_clk=0 and tick=0 SHALL hold; run=1 sampled SHALL move the FSM to RUN with counter=0 on the next cycle.
REQ-016 In RUN and DRAIN, counter SHALL increment each cycle; when counter==div_reg ("wrap"), counter SHALL return to 0, divided_clk SHALL toggle, and tick SHALL be 1 for that one cycle, all registered together.
REQ-017 With div_reg=N, the first toggle SHALL occur N+1 cycles after entry to RUN, and the period SHALL be 2(N+1) cycles; N=0 SHALL give clk/2.
REQ-018 In RUN or DRAIN, an accepted cfg_div SHALL go to pend_reg and set pend_valid; at the next wrap, div_reg<=pend_reg and pend_valid<=0.
REQ-019 A transfer on the same cycle as a wrap SHALL take effect at the following wrap, not the current one.
REQ-020 run=0 sampled in RUN SHALL move the FSM to DRAIN; the current half-period SHALL complete unchanged.
REQ-021 In DRAIN, a wrap that sets divided_clk to 0 SHALL move the FSM to IDLE with counter=0; a wrap that sets divided_clk to 1 SHALL leave the FSM in DRAIN.
REQ-022 run=1 sampled in DRAIN SHALL return the FSM to RUN with no phase disturbance.
REQ-023 Counter arithmetic SHALL be WIDTH bits unsigned; the counter SHALL never exceed div_reg.

Reset
REQ-024 When rst=1 at an edge, the block SHALL set state=IDLE, counter=0, div_reg=DIV_INIT, pend_valid=0, divided_clk=0, tick=0, cfg_ready=1 and busy=0, overriding all other inputs.
REQ-025 A reset mid-period SHALL discard pend_reg and the partial count; generation SHALL restart only after run is seen high again post-reset.

Configuration
REQ-026 When CLKDIV_TICKCNT_EN is defined, the block SHALL add output tick_count (32 bits), which increments on each tick, wraps at 2^32-1 to 0, and clears on reset and on entry to IDLE.
REQ-027 When CLKDIV_TICKCNT_EN is undefined, the tick_count port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-028 Package clkdiv_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and the DIV_INIT default constant.
REQ-029 The counter, compare and toggle logic SHALL live in sub-module clkdiv_core, with inputs en, clr and div, and outputs wrap and divided_clk; the FSM and handshake SHALL live in clkdiv_sequencer.

Verification
REQ-030 The bench SHALL cover: reset, run=1, DIV_INIT=3124 -> first tick 3125 cycles after RUN entry, and a divided_clk period of 6250 cycles.
REQ-031 The bench SHALL cover: in IDLE, cfg_div=4 accepted, then run=1 -> toggles every 5 cycles, and cfg_ready stays 1.
REQ-032 The bench SHALL cover: in RUN with div=9, cfg_div=2 offered at counter=4 -> cfg_ready=0 until the next wrap, then a 3-cycle half-period follows.
REQ-033 The bench SHALL cover: cfg accepted exactly on a wrap cycle -> the old div is used for one more half-period before the new one.
REQ-034 The bench SHALL cover: run dropped while divided_clk=1, div=4 -> DRAIN, IDLE at the next falling toggle, and busy=0 with divided_clk=0 after it.
REQ-035 The bench SHALL cover: rst pulsed mid-period with pend_valid=1 -> all outputs at reset values next cycle, and div_reg=3124.
